// File: rtl/dmem_pkg.sv
// dmem_pkg: FSM state encoding and default parameters shared by the data memory controller.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF = 128;
  localparam int ADDR_W_DEF = 32;
  localparam int WAIT_CYCLES_DEF = 1;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W storage with async clear, byte-masked write and registered read.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 128,
  parameter int IDX_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mask;
  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_mask
    assign mask[b*8 +: 8] = {8{strb[b]}};
  end
  // a write access leaves zero in rdata so write responses carry no data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else if (en) begin
      if (we) mem[idx] <= (mem[idx] & ~mask) | (wdata & mask);
      rdata <= we ? '0 : mem[idx];
    end
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding request/response data memory controller with wait states.
// Byte strobes on writes are enabled by defining DMEM_BYTE_STRB_EN.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
`ifdef DMEM_BYTE_STRB_EN
  input  logic [DATA_W/8-1:0] req_strb,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_r;
  logic [DATA_W-1:0] wdata_r, rdata;
  logic [DATA_W/8-1:0] strb_r;
  logic we_r, err_r, acc;
  always_comb begin
    state_nx = state;
    acc = state == WAIT && cnt == '0;
    state_nx = state == IDLE ? (req_valid ? WAIT : IDLE)
             : state == WAIT ? (acc ? RESP : WAIT)
             : (rsp_ready ? IDLE : RESP);
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    rsp_err = rsp_valid && err_r;
    rsp_rdata = rsp_valid && !err_r ? rdata : '0;
  end
  // counter is loaded with WAIT_CYCLES so the access lands WAIT_CYCLES+1 edges after accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx_r <= '0;
      wdata_r <= '0;
      we_r <= 1'b0;
      err_r <= 1'b0;
`ifdef DMEM_BYTE_STRB_EN
      strb_r <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        cnt <= CNT_W'(WAIT_CYCLES);
        idx_r <= req_addr[IDX_W-1:0];
        wdata_r <= req_wdata;
        we_r <= req_we;
        err_r <= req_addr >= ADDR_W'(DEPTH);
`ifdef DMEM_BYTE_STRB_EN
        strb_r <= req_strb;
`endif
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
`ifndef DMEM_BYTE_STRB_EN
  assign strb_r = '1;
`endif
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk(clk),
    .reset(reset),
    .en(acc && !err_r),
    .we(we_r),
    .idx(idx_r),
    .wdata(wdata_r),
    .strb(strb_r),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of data_mem_ctrl at WAIT_CYCLES 1, 0 and 3.
module tb_data_mem_ctrl;
  localparam int WC [3] = '{1, 0, 3};
  logic clk = 0;
  logic reset = 1;
  logic [2:0] req_valid_v = '0, req_ready_v, rsp_valid_v, rsp_ready_v = '0, rsp_err_v;
  logic req_we = 0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_strb = '1;
  logic [31:0] rdata_v [3];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    data_mem_ctrl #(.WAIT_CYCLES(WC[k])) u_dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid_v[k]),
      .req_ready(req_ready_v[k]),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STRB_EN
      .req_strb(req_strb),
`endif
      .rsp_valid(rsp_valid_v[k]),
      .rsp_ready(rsp_ready_v[k]),
      .rsp_rdata(rdata_v[k]),
      .rsp_err(rsp_err_v[k])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic do_req(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] sb, output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    req_strb = sb;
    req_valid_v[k] = 1'b1;
    @(posedge clk);
    #1 req_valid_v[k] = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid_v[k]) break;
    end
    if (!rsp_valid_v[k]) check("rsp_timeout", 32'(rsp_valid_v[k]), 1);
    rd = rdata_v[k];
    e = rsp_err_v[k];
    rsp_ready_v[k] = 1'b1;
    @(posedge clk);
    #1 rsp_ready_v[k] = 1'b0;
  endtask
  logic [31:0] rd;
  logic e, seen;
  int lat;
  initial begin
    #1;
    check("rst_valid", 32'(rsp_valid_v), 0);
    check("rst_rdata", rdata_v[0], 0);
    check("rst_err", 32'(rsp_err_v), 0);
    @(negedge clk);
    reset = 0;
    #1 check("rst_ready", 32'(req_ready_v), 32'h7);
    do_req(0, 1, 5, 32'hDEADBEEF, 4'hF, rd, e, lat);
    check("wr5_lat", lat, 2);
    check("wr5_rdata", rd, 0);
    check("wr5_err", 32'(e), 0);
    do_req(0, 0, 5, 0, 4'hF, rd, e, lat);
    check("rd5_lat", lat, 2);
    check("rd5_rdata", rd, 32'hDEADBEEF);
    check("rd5_err", 32'(e), 0);
    do_req(0, 1, 127, 32'hCAFEF00D, 4'hF, rd, e, lat);
    do_req(0, 0, 128, 0, 4'hF, rd, e, lat);
    check("oor_lat", lat, 2);
    check("oor_rdata", rd, 0);
    check("oor_err", 32'(e), 1);
    do_req(0, 1, 32'h200, 32'h0BADF00D, 4'hF, rd, e, lat);
    check("oor_wr_err", 32'(e), 1);
    do_req(0, 0, 127, 0, 4'hF, rd, e, lat);
    check("rd127_rdata", rd, 32'hCAFEF00D);
    check("rd127_err", 32'(e), 0);
    do_req(0, 0, 0, 0, 4'hF, rd, e, lat);
    check("rd0_alias", rd, 0);
    @(negedge clk);
    req_we = 0;
    req_addr = 5;
    req_valid_v[0] = 1'b1;
    @(posedge clk);
    #1 req_valid_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stall_valid0", 32'(rsp_valid_v[0]), 1);
    req_valid_v[0] = 1'b1;
    req_we = 1;
    req_addr = 127;
    req_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 32'(rsp_valid_v[0]), 1);
      check("stall_rdata", rdata_v[0], 32'hDEADBEEF);
      check("stall_ready", 32'(req_ready_v[0]), 0);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid_v[0] = 1'b0;
    rsp_ready_v[0] = 1'b1;
    @(posedge clk);
    #1 rsp_ready_v[0] = 1'b0;
    @(negedge clk);
    check("stall_done_ready", 32'(req_ready_v[0]), 1);
    check("stall_done_valid", 32'(rsp_valid_v[0]), 0);
    do_req(0, 0, 127, 0, 4'hF, rd, e, lat);
    check("ignored_wr", rd, 32'hCAFEF00D);
    do_req(1, 1, 1, 32'h00000055, 4'hF, rd, e, lat);
    check("w0_wr_lat", lat, 1);
    do_req(1, 0, 1, 0, 4'hF, rd, e, lat);
    check("w0_rd_lat", lat, 1);
    check("w0_rd_rdata", rd, 32'h55);
    do_req(2, 1, 2, 32'hA5A5A5A5, 4'hF, rd, e, lat);
    check("w3_wr_lat", lat, 4);
    do_req(2, 0, 2, 0, 4'hF, rd, e, lat);
    check("w3_rd_lat", lat, 4);
    check("w3_rd_rdata", rd, 32'hA5A5A5A5);
    @(negedge clk);
    req_we = 1;
    req_addr = 9;
    req_wdata = 32'h12345678;
    req_valid_v[2] = 1'b1;
    @(posedge clk);
    #1 req_valid_v[2] = 1'b0;
    @(negedge clk);
    reset = 1;
    #1 check("abort_valid", 32'(rsp_valid_v[2]), 0);
    @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= rsp_valid_v[2];
    end
    check("abort_no_rsp", 32'(seen), 0);
    check("abort_ready", 32'(req_ready_v[2]), 1);
    do_req(2, 0, 9, 0, 4'hF, rd, e, lat);
    check("abort_rd9", rd, 0);
    do_req(0, 0, 5, 0, 4'hF, rd, e, lat);
    check("clr_rd5", rd, 0);
`ifdef DMEM_BYTE_STRB_EN
    do_req(0, 1, 20, 32'hAABBCCDD, 4'hF, rd, e, lat);
    do_req(0, 1, 20, 32'h11223344, 4'b0101, rd, e, lat);
    do_req(0, 0, 20, 0, 4'b0000, rd, e, lat);
    check("strb_rd", rd, 32'hAA22CC44);
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
